// File: rtl/lcv_div_iter.sv
// Iterative radix-2 restoring divider, one quotient bit per cycle, signed or unsigned,
// with valid/ready on both sides and fixed WIDTH+1 cycle latency.
module lcv_div_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] dvd, dvs, rem;
    logic [CW-1:0]    cnt;
    logic             neg_q, neg_r, dz, ov;

    logic             a_neg, b_neg, qbit;
    logic [WIDTH-1:0] a_mag, b_mag, q_next, r_next, q_fix, r_fix;
    logic [WIDTH:0]   part, diff;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_comb begin
        a_neg = is_signed & dividend[WIDTH-1];
        b_neg = is_signed & divisor[WIDTH-1];
        a_mag = a_neg ? -dividend : dividend;
        b_mag = b_neg ? -divisor : divisor;

        // dvd shifts dividend bits out of its MSB while quotient bits enter at the LSB
        part   = {rem, dvd[WIDTH-1]};
        diff   = part - {1'b0, dvs};
        qbit   = ~diff[WIDTH];
        q_next = {dvd[WIDTH-2:0], qbit};
        r_next = qbit ? diff[WIDTH-1:0] : part[WIDTH-1:0];

        // A zero divisor yields all-ones magnitude; force all ones regardless of sign.
        // The remainder fix-up already reproduces the original dividend in that case.
        q_fix = neg_q ? -q_next : q_next;
        if (dz) q_fix = '1;
        r_fix = neg_r ? -r_next : r_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            dvd         <= '0;
            dvs         <= '0;
            rem         <= '0;
            cnt         <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            dz          <= 1'b0;
            ov          <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        dvd   <= a_mag;
                        dvs   <= b_mag;
                        rem   <= '0;
                        cnt   <= CW'(WIDTH);
                        neg_q <= a_neg ^ b_neg;
                        neg_r <= a_neg;
                        dz    <= (divisor == '0);
                        ov    <= is_signed && (dividend == {1'b1, {(WIDTH-1){1'b0}}})
                                 && (divisor == '1);
                        state <= RUN;
                    end
                end
                RUN: begin
                    dvd <= q_next;
                    rem <= r_next;
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        quotient    <= q_fix;
                        remainder   <= r_fix;
                        div_by_zero <= dz;
                        overflow    <= ov;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lcv_div_iter.sv
// Directed-vector bench for lcv_div_iter at WIDTH=32.
module tb_lcv_div_iter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0, in_ready;
    logic        is_signed = 1'b0;
    logic [31:0] dividend = '0, divisor = '0;
    logic        out_valid, out_ready = 1'b0;
    logic [31:0] quotient, remainder;
    logic        div_by_zero, overflow;

    int checks = 0;
    int errors = 0;

    lcv_div_iter #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .is_signed(is_signed), .dividend(dividend), .divisor(divisor),
        .out_valid(out_valid), .out_ready(out_ready), .quotient(quotient),
        .remainder(remainder), .div_by_zero(div_by_zero), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic s);
        @(negedge clk);
        dividend = a; divisor = b; is_signed = s; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Returns negedges from accept to first out_valid, or 0 on timeout.
    task automatic wait_done(output int lat);
        lat = 0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_hs: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
        end
        checks++;
        if ({quotient, remainder, div_by_zero, overflow} !== 66'd0) begin
            errors++;
            $display("FAIL reset_out: q=%h r=%h dz=%b ov=%b want all 0",
                     quotient, remainder, div_by_zero, overflow);
        end
    endtask

    // Normal and special-case divides: operands, mode, expected q/r/dz/ov; all at 33-cycle latency.
    task automatic test_divides();
        logic [31:0] va[8] = '{32'd100, -32'sd100, 32'd100, 32'hFFFFFFFF, 32'hFFFFFFFF,
                               32'd7, -32'sd7, 32'h80000000};
        logic [31:0] vb[8] = '{32'd7, 32'd7, -32'sd7, 32'd2, 32'd2, 32'd0, 32'd0, 32'hFFFFFFFF};
        logic        vs[8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [31:0] eq[8] = '{32'd14, 32'hFFFFFFF2, 32'hFFFFFFF2, 32'h7FFFFFFF, 32'd0,
                               32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000};
        logic [31:0] er[8] = '{32'd2, 32'hFFFFFFFE, 32'd2, 32'd1, 32'hFFFFFFFF,
                               32'd7, 32'hFFFFFFF9, 32'd0};
        logic [1:0]  ef[8] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b10, 2'b01};
        int lat;
        for (int i = 0; i < 8; i++) begin
            start_op(va[i], vb[i], vs[i]);
            wait_done(lat);
            checks++;
            if (lat !== 33) begin
                errors++;
                $display("FAIL lat[%0d]: got %0d want 33", i, lat);
            end
            checks++;
            if (quotient !== eq[i] || remainder !== er[i]) begin
                errors++;
                $display("FAIL qr[%0d]: q=%h r=%h want q=%h r=%h", i, quotient, remainder, eq[i], er[i]);
            end
            checks++;
            if ({div_by_zero, overflow} !== ef[i]) begin
                errors++;
                $display("FAIL flags[%0d]: dz,ov=%b want %b", i, {div_by_zero, overflow}, ef[i]);
            end
            if (out_valid) consume();
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        start_op(32'd50, 32'd3, 1'b0);
        repeat (4) @(negedge clk);
        dividend = 32'd5; divisor = 32'd1; in_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL run_ready: in_ready=%b want 0", in_ready);
        end
        in_valid = 1'b0;
        wait_done(lat);
        checks++;
        if (quotient !== 32'd16 || remainder !== 32'd2) begin
            errors++;
            $display("FAIL ignore_in: q=%0d r=%0d want 16 2", quotient, remainder);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || quotient !== 32'd16 || remainder !== 32'd2) begin
                errors++;
                $display("FAIL hold[%0d]: ov=%b ir=%b q=%0d r=%0d want 1 0 16 2",
                         i, out_valid, in_ready, quotient, remainder);
            end
        end
        consume();
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_consume: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
        end
        start_op(32'd9, 32'd4, 1'b0);
        wait_done(lat);
        checks++;
        if (lat !== 33 || quotient !== 32'd2 || remainder !== 32'd1) begin
            errors++;
            $display("FAIL next_op: lat=%0d q=%0d r=%0d want 33 2 1", lat, quotient, remainder);
        end
        if (out_valid) consume();
    endtask

    task automatic test_reset_mid();
        int  lat;
        logic seen = 1'b0;
        start_op(32'd1234, 32'd5, 1'b0);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 ||
            {quotient, remainder, div_by_zero, overflow} !== 66'd0) begin
            errors++;
            $display("FAIL mid_reset: ir=%b ov=%b q=%h r=%h dz=%b of=%b want 1 0 0 0 0 0",
                     in_ready, out_valid, quotient, remainder, div_by_zero, overflow);
        end
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL aborted_valid: out_valid seen=%b want 0", seen);
        end
        start_op(32'd1000, 32'd10, 1'b1);
        wait_done(lat);
        checks++;
        if (lat !== 33 || quotient !== 32'd100 || remainder !== 32'd0) begin
            errors++;
            $display("FAIL fresh_op: lat=%0d q=%0d r=%0d want 33 100 0", lat, quotient, remainder);
        end
        if (out_valid) consume();
    endtask

    initial begin
        test_reset();
        test_divides();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
